// File: rtl/uart_pkg.sv
// Shared UART receive types and default frame parameters.
package uart_pkg;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Reset loads both flops with RST_VAL so no false edge is seen when reset is released.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver using 16x oversampling: it finds the middle of the start bit, then samples each data bit at its centre.
// It produces a one-clk rx_done_tick together with frame_err. There is no backpressure.
module uart_rx #(
  parameter int DBIT    = uart_pkg::DBIT_DEF,
  parameter int SB_TICK = uart_pkg::SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);
  import uart_pkg::*;

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_MID  = 5'd7;
  localparam logic [4:0]    S_BIT  = 5'd15;
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  state_t          state;
  logic [4:0]      s;    // 5 bits so that a 2-stop-bit count (31) fits
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        START:
          if (s_tick) begin
            if (s == S_MID) begin
              // A line that is high again at mid-start was a glitch.
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        DATA:
          if (s_tick) begin
            if (s == S_BIT) begin
              b <= {rx_s, b[DBIT-1:1]};
              s <= '0;
              if (n == N_LAST) state <= STOP;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        STOP:
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              rx_done_tick <= 1'b1;
              frame_err    <= ~rx_s;
            end else begin
              s <= s + 5'd1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end

  assign dout = b;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame table, hand-written corner sequences and random frames.
// Received words are checked against a queue of predicted frames that carries their start times.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout16, dout32;
  logic       done16, done32, ferr16, ferr32;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut16 (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout16), .rx_done_tick(done16), .frame_err(ferr16)
  );
  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout32), .rx_done_tick(done32), .frame_err(ferr32)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sel32 = 1'b0;

  typedef struct { logic [7:0] data; logic ferr; int start; } exp_t;
  exp_t expq[$];

  int         npulse = 0;
  logic [7:0] last_dout = '0;
  logic       last_ferr = 1'b0;
  int         last_lat = 0;

  typedef struct { logic [7:0] data; bit stop_ok; logic [7:0] exp_dout; logic exp_ferr; } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  // The model predicts each frame from its own bits: the data is the word sent, and frame_err is set when the stop level is low.
  // A low stop bit is held low past the stop sample and then released, and an idle gap follows it.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_clks, input bit predict);
    exp_t e;
    e.data = d; e.ferr = ~stop_ok; e.start = cyc;
    if (predict) expq.push_back(e);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(64);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clks(stop_clks);
    end else begin
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(stop_clks - 40 + 128);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(10);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    s_tick = (cyc % 4 == 0);
  end

  // Scoreboard: each pulse must match the oldest predicted frame. It must arrive about 9.5 bit times
  // (plus one extra bit for two stop bits) after its start edge, and it must not repeat on the next clk.
  initial begin
    logic d, prev_d, f;
    logic [7:0] o;
    exp_t e;
    int lo;
    prev_d = 1'b0;
    forever begin
      @(negedge clk);
      d = sel32 ? done32 : done16;
      o = sel32 ? dout32 : dout16;
      f = sel32 ? ferr32 : ferr16;
      if (d) begin
        check("single_cycle_pulse", {31'd0, prev_d}, 32'd0);
        npulse++;
        last_dout = o;
        last_ferr = f;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got dout=%0h with no frame pending, required none", o);
        end else begin
          e = expq.pop_front();
          last_lat = cyc - e.start;
          lo = sel32 ? 670 : 606;
          check("sb_dout", {24'd0, o}, {24'd0, e.data});
          check("sb_frame_err", {31'd0, f}, {31'd0, e.ferr});
          checks++;
          if (last_lat < lo || last_lat > lo + 7) begin
            errors++;
            $display("FAIL latency: got %0d clk, required %0d..%0d", last_lat, lo, lo + 7);
          end
        end
      end
      prev_d = d;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int p0, lat16;
    logic [7:0] rd;
    bit ok;

    tbl[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
    tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    tbl[3] = '{8'hE1, 1'b0, 8'hE1, 1'b1};

    // Reset state
    wait_clks(4);
    check("reset_dout", {24'd0, dout16}, 32'd0);
    check("reset_done", {31'd0, done16}, 32'd0);
    check("reset_ferr", {31'd0, ferr16}, 32'd0);
    check("reset_dout32", {24'd0, dout32}, 32'd0);
    check("reset_state", {30'd0, dut16.state}, {30'd0, IDLE});
    reset = 1'b0;
    wait_clks(20);
    check("idle_no_pulse", npulse, 0);

    // Table-driven frames (good and low stop bits)
    for (int i = 0; i < 4; i++) begin
      p0 = npulse;
      align();
      send_frame(tbl[i].data, tbl[i].stop_ok, 64, 1'b1);
      check("tbl_pulse_count", npulse - p0, 1);
      check("tbl_dout", {24'd0, last_dout}, {24'd0, tbl[i].exp_dout});
      check("tbl_ferr", {31'd0, last_ferr}, {31'd0, tbl[i].exp_ferr});
      check("tbl_idle_after", {30'd0, dut16.state}, {30'd0, IDLE});
    end

    // Short glitch of 5 ticks is rejected, then a good frame
    p0 = npulse;
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(200);
    check("glitch_no_pulse", npulse - p0, 0);
    check("glitch_idle", {30'd0, dut16.state}, {30'd0, IDLE});
    send_frame(8'h0F, 1'b1, 64, 1'b1);
    check("after_glitch_dout", {24'd0, last_dout}, 32'h0F);

    // Back-to-back frames with no idle gap
    p0 = npulse;
    send_frame(8'h00, 1'b1, 64, 1'b1);
    send_frame(8'hFF, 1'b1, 64, 1'b1);
    send_frame(8'h81, 1'b1, 64, 1'b1);
    wait_clks(10);
    check("b2b_pulse_count", npulse - p0, 3);
    check("b2b_last_dout", {24'd0, last_dout}, 32'h81);

    // Reset during data bit 4 of 0x3C aborts that frame
    p0 = npulse;
    rd = 8'h3C;
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      wait_clks(64);
    end
    rx = rd[4];
    wait_clks(32);
    do_reset();
    wait_clks(200);
    check("abort_no_pulse", npulse - p0, 0);
    check("abort_dout_cleared", {24'd0, dout16}, 32'd0);
    send_frame(8'hC3, 1'b1, 64, 1'b1);
    check("resume_dout", {24'd0, last_dout}, 32'hC3);
    check("resume_pulse_count", npulse - p0, 1);

    // A two-stop-bit receiver finishes 16 ticks (64 clk) later than the one-stop-bit receiver
    align();
    send_frame(8'h7E, 1'b1, 64, 1'b1);
    lat16 = last_lat;
    do_reset();
    sel32 = 1'b1;
    p0 = npulse;
    align();
    send_frame(8'h7E, 1'b1, 128, 1'b1);
    check("sb32_pulse_count", npulse - p0, 1);
    check("sb32_dout", {24'd0, last_dout}, 32'h7E);
    check("sb32_extra_delay", last_lat - lat16, 64);
    do_reset();
    sel32 = 1'b0;

    // Random frames against the model
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rd, ok, 64, 1'b1);
      wait_clks($urandom_range(0, 100));
    end
    wait_clks(50);
    check("all_frames_received", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
